// File: rtl/keypad_operand_entry.sv
// keypad_operand_entry: collects hex keypad digits into a sign-magnitude operand
// of N bits, with backspace, sign toggle, clear, and a valid/ready hand-off
// to a downstream stage.
//
// Optional feature: define LEADING_ZERO_SUPPRESS_EN to drop a 0 digit typed
// while the entry is empty, so leading zeros never use up a digit position.

module keypad_operand_entry #(
    parameter int unsigned N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic        key_ready,
    output logic [15:0] hex_out,
    output logic        sign,
    output logic [2:0]  digit_count,
    output logic        operand_valid,
    input  logic        operand_ready,
    output logic        overflow
);

    localparam int unsigned DIGITS = N / 4;
    localparam logic [2:0]  MaxDigits = 3'(DIGITS);
    // The magnitude must stay below 2**(N-1); the top bit belongs to the sign.
    localparam logic [15:0] Limit = 16'(1 << (N - 1));

    localparam logic [4:0] KeyClear = 5'd16;
    localparam logic [4:0] KeyBksp  = 5'd17;
    localparam logic [4:0] KeyNeg   = 5'd18;
    localparam logic [4:0] KeyEnter = 5'd19;

`ifdef LEADING_ZERO_SUPPRESS_EN
    localparam bit SuppressLeadingZero = 1'b1;
`else
    localparam bit SuppressLeadingZero = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StEntry = 2'd1,
        StHold  = 2'd2
    } state_e;

    state_e      state_q;
    logic [15:0] hex_q;
    logic        sign_q;
    logic [2:0]  count_q;
    logic        valid_q;
    logic        ready_q;
    logic        ovf_q;

    logic        key_fire;
    logic        is_digit;
    logic [3:0]  digit;
    logic [15:0] shifted;
    logic        digit_fits;
    logic        zero_dropped;

    // Decode the incoming key and pre-compute the digit acceptance test.
    always_comb begin
        key_fire     = key_valid && ready_q;
        is_digit     = ~key_code[4];
        digit        = key_code[3:0];
        shifted      = {hex_q[11:0], digit};
        digit_fits   = (count_q < MaxDigits) && (shifted < Limit);
        zero_dropped = SuppressLeadingZero && (state_q == StIdle) && (digit == 4'd0);
    end

    // Entry FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hex_q   <= '0;
            sign_q  <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            // overflow is a single-cycle pulse unless re-armed by a new rejection
            ovf_q <= 1'b0;
            unique case (state_q)
                StIdle, StEntry: begin
                    if (key_fire) begin
                        if (is_digit) begin
                            if (!zero_dropped) begin
                                if (digit_fits) begin
                                    hex_q   <= shifted;
                                    count_q <= count_q + 3'd1;
                                    state_q <= StEntry;
                                end else begin
                                    ovf_q <= 1'b1;
                                end
                            end
                        end else begin
                            case (key_code)
                                KeyClear: begin
                                    hex_q   <= '0;
                                    sign_q  <= 1'b0;
                                    count_q <= '0;
                                    state_q <= StIdle;
                                end
                                KeyBksp: begin
                                    if (state_q == StEntry) begin
                                        hex_q   <= hex_q >> 4;
                                        count_q <= count_q - 3'd1;
                                        if (count_q == 3'd1) begin
                                            state_q <= StIdle;
                                        end
                                    end
                                end
                                KeyNeg: begin
                                    sign_q <= ~sign_q;
                                end
                                KeyEnter: begin
                                    if (state_q == StEntry) begin
                                        state_q <= StHold;
                                        valid_q <= 1'b1;
                                        ready_q <= 1'b0;
                                    end
                                end
                                // codes 20-31 complete the handshake and do nothing
                                default: ;
                            endcase
                        end
                    end
                end
                StHold: begin
                    if (operand_ready) begin
                        hex_q   <= '0;
                        sign_q  <= 1'b0;
                        count_q <= '0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Drive the ports straight from the state registers.
    always_comb begin
        key_ready     = ready_q;
        hex_out       = hex_q;
        sign          = sign_q;
        digit_count   = count_q;
        operand_valid = valid_q;
        overflow      = ovf_q;
    end

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry (N = 8): directed vector table, a few
// hand-written multi-cycle sequences, then random keys against a queue model.

module tb_keypad_operand_entry;

    localparam int unsigned N = 8;
    localparam int unsigned DIGITS = N / 4;
`ifdef LEADING_ZERO_SUPPRESS_EN
    localparam bit SUPPRESS = 1'b1;
`else
    localparam bit SUPPRESS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_ready;
    logic [15:0] hex_out;
    logic        sign;
    logic [2:0]  digit_count;
    logic        operand_valid;
    logic        operand_ready;
    logic        overflow;

    keypad_operand_entry #(.N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_ready     (key_ready),
        .hex_out       (hex_out),
        .sign          (sign),
        .digit_count   (digit_count),
        .operand_valid (operand_valid),
        .operand_ready (operand_ready),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        kv;
        logic [4:0]  kc;
        logic        ordy;
        logic [15:0] hex;
        logic        sgn;
        logic [2:0]  cnt;
        logic        val;
        logic        rdy;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: entered digits as a list, plus sign and "presented" flag.
    int digs[$];
    bit m_neg;
    bit m_held;
    bit m_ovf;

    function automatic vec_t mk(input logic rstn, input logic kv, input logic [4:0] kc,
                                input logic ordy, input logic [15:0] hex, input logic sgn,
                                input logic [2:0] cnt, input logic val, input logic rdy,
                                input logic ovf);
        vec_t v;
        v.rstn = rstn; v.kv = kv; v.kc = kc; v.ordy = ordy;
        v.hex = hex; v.sgn = sgn; v.cnt = cnt; v.val = val; v.rdy = rdy; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] hex, input logic sgn,
                             input logic [2:0] cnt, input logic val, input logic rdy,
                             input logic ovf);
        check({tag, " hex_out"}, hex_out, hex);
        check({tag, " sign"}, 16'(sign), 16'(sgn));
        check({tag, " digit_count"}, 16'(digit_count), 16'(cnt));
        check({tag, " operand_valid"}, 16'(operand_valid), 16'(val));
        check({tag, " key_ready"}, 16'(key_ready), 16'(rdy));
        check({tag, " overflow"}, 16'(overflow), 16'(ovf));
    endtask

    // Drive one cycle of inputs, let the edge happen, settle 1 time unit after it.
    task automatic apply(input logic rstn, input logic kv, input logic [4:0] kc,
                         input logic ordy);
        rst_n         = rstn;
        key_valid     = kv;
        key_code      = kc;
        operand_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    function automatic int model_value();
        int v = 0;
        foreach (digs[i]) v = v * 16 + digs[i];
        return v;
    endfunction

    task automatic model_clear();
        digs.delete();
        m_neg  = 1'b0;
        m_held = 1'b0;
    endtask

    task automatic model_step(input logic rstn, input logic kv, input logic [4:0] kc,
                              input logic ordy);
        int k = int'(kc);
        m_ovf = 1'b0;
        if (!rstn) begin
            model_clear();
        end else if (m_held) begin
            if (ordy) model_clear();
        end else if (kv) begin
            if (k < 16) begin
                if (SUPPRESS && digs.size() == 0 && k == 0) begin
                    // leading zero dropped
                end else if (digs.size() < DIGITS && model_value() * 16 + k < (1 << (N - 1))) begin
                    digs.push_back(k);
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (k == 16) begin
                model_clear();
            end else if (k == 17) begin
                if (digs.size() > 0) digs.delete(digs.size() - 1);
            end else if (k == 18) begin
                m_neg = !m_neg;
            end else if (k == 19) begin
                if (digs.size() > 0) m_held = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_code = 5'd0; operand_ready = 1'b0;

        // rstn kv kc ordy | hex sgn cnt val rdy ovf
        tbl.push_back(mk(0, 0, 5'd0,  0, 16'h0000, 0, 3'd0, 0, 1, 0));  // reset
        // keys 3, A, ENTER, then downstream accept
        tbl.push_back(mk(1, 1, 5'd3,  0, 16'h0003, 0, 3'd1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd10, 0, 16'h003A, 0, 3'd2, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd19, 0, 16'h003A, 0, 3'd2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 5'd0,  0, 16'h003A, 0, 3'd2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 5'd0,  1, 16'h0000, 0, 3'd0, 0, 1, 0));
        // keys 7, F, 5: third digit rejected, one-cycle overflow
        tbl.push_back(mk(1, 1, 5'd7,  0, 16'h0007, 0, 3'd1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd15, 0, 16'h007F, 0, 3'd2, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd5,  0, 16'h007F, 0, 3'd2, 0, 1, 1));
        tbl.push_back(mk(1, 0, 5'd0,  0, 16'h007F, 0, 3'd2, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd16, 0, 16'h0000, 0, 3'd0, 0, 1, 0));
        // keys 8, 0: 0x80 is not below 0x80
        tbl.push_back(mk(1, 1, 5'd8,  0, 16'h0008, 0, 3'd1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd0,  0, 16'h0008, 0, 3'd1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 5'd0,  0, 16'h0008, 0, 3'd1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd16, 0, 16'h0000, 0, 3'd0, 0, 1, 0));
        // keys 4, 2, BKSP, NEG, ENTER
        tbl.push_back(mk(1, 1, 5'd4,  0, 16'h0004, 0, 3'd1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd2,  0, 16'h0042, 0, 3'd2, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd17, 0, 16'h0004, 0, 3'd1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd18, 0, 16'h0004, 1, 3'd1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd19, 0, 16'h0004, 1, 3'd1, 1, 0, 0));
        // key 9 offered in HOLD is refused, then reset from HOLD
        tbl.push_back(mk(1, 1, 5'd9,  0, 16'h0004, 1, 3'd1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 5'd9,  0, 16'h0000, 0, 3'd0, 0, 1, 0));
        // ignored keys in IDLE: code 25, BKSP, ENTER; NEG then CLEAR
        tbl.push_back(mk(1, 1, 5'd25, 0, 16'h0000, 0, 3'd0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd17, 0, 16'h0000, 0, 3'd0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd19, 0, 16'h0000, 0, 3'd0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd18, 0, 16'h0000, 1, 3'd0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd16, 0, 16'h0000, 0, 3'd0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 5'd6,  0, 16'h0000, 0, 3'd0, 0, 1, 0));  // not valid
        // keys 0, 0, 5 (leading-zero behaviour depends on build)
        tbl.push_back(mk(1, 1, 5'd0,  0, 16'h0000, 0, SUPPRESS ? 3'd0 : 3'd1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd0,  0, 16'h0000, 0, SUPPRESS ? 3'd0 : 3'd2, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5'd5,  0, SUPPRESS ? 16'h0005 : 16'h0000, 0,
                         SUPPRESS ? 3'd1 : 3'd2, 0, 1, SUPPRESS ? 1'b0 : 1'b1));
        tbl.push_back(mk(1, 0, 5'd0,  0, SUPPRESS ? 16'h0005 : 16'h0000, 0,
                         SUPPRESS ? 3'd1 : 3'd2, 0, 1, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].rstn, tbl[i].kv, tbl[i].kc, tbl[i].ordy);
            check_all($sformatf("vec%0d", i), tbl[i].hex, tbl[i].sgn, tbl[i].cnt,
                      tbl[i].val, tbl[i].rdy, tbl[i].ovf);
        end

        // Back-to-back rejected digits: one pulse cycle per rejected key.
        apply(0, 0, 5'd0, 0);
        apply(1, 1, 5'd7, 0);
        apply(1, 1, 5'd15, 0);
        apply(1, 1, 5'd5, 0);
        check_all("b2b rej1", 16'h007F, 0, 3'd2, 0, 1, 1);
        apply(1, 1, 5'd6, 0);
        check_all("b2b rej2", 16'h007F, 0, 3'd2, 0, 1, 1);
        apply(1, 0, 5'd0, 0);
        check_all("b2b end", 16'h007F, 0, 3'd2, 0, 1, 0);

        // HOLD stays stable across several cycles of ignored keys.
        apply(1, 1, 5'd18, 0);
        apply(1, 1, 5'd19, 0);
        for (int i = 0; i < 4; i++) begin
            apply(1, 1, 5'(i * 5), 0);
            check_all($sformatf("hold%0d", i), 16'h007F, 1, 3'd2, 1, 0, 0);
        end
        apply(1, 0, 5'd0, 1);
        check_all("hold release", 16'h0000, 0, 3'd0, 0, 1, 0);

        // Random keys against the model.
        apply(0, 0, 5'd0, 0);
        model_clear();
        m_ovf = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic       r_rstn;
            logic       r_kv;
            logic [4:0] r_kc;
            logic       r_ordy;
            r_rstn = ($urandom_range(0, 99) != 0);
            r_kv   = ($urandom_range(0, 99) < 60);
            r_kc   = ($urandom_range(0, 9) < 6) ? 5'($urandom_range(0, 15))
                                                : 5'($urandom_range(16, 31));
            r_ordy = ($urandom_range(0, 99) < 25);
            model_step(r_rstn, r_kv, r_kc, r_ordy);
            apply(r_rstn, r_kv, r_kc, r_ordy);
            check_all($sformatf("rnd%0d", i), 16'(model_value()), m_neg,
                      3'(digs.size()), m_held, !m_held, m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
